// File: rtl/xsleena_io_ctrl.sv
// Xain'd Sleena IO window: address-decoded read/write strobes, read-port mux,
// control latches, and per-channel coin debounce with paced coin-counter pulses.
module xsleena_io_ctrl #(
  parameter int NUM_RD_PORTS = 6,
  parameter int NUM_COIN     = 2,
  parameter int DEB_CYC      = 16,
  parameter int PULSE_CYC    = 64
) (
  input  logic                      clk,
  input  logic                      RSTn,
  input  logic [3:0]                AB,
  input  logic                      IOn,
  input  logic                      RW,
  input  logic [7:0]                DB_in,
  output logic [7:0]                DB_out,
  input  logic [8*NUM_RD_PORTS-1:0] RD_PORTS,
  input  logic [NUM_COIN-1:0]       COINn,
  output logic [15:0]               WR_STRB,
  output logic [15:0]               RD_STRB,
  output logic [NUM_COIN-1:0]       COIN_DBn,
  output logic [NUM_COIN-1:0]       CUNT,
  output logic [2:0]                PRI,
  output logic                      BSL,
  output logic                      P1_P2n
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] DEB_LAST   = 8'(DEB_CYC - 1);
  localparam logic [7:0] DEB_MAX    = 8'(DEB_CYC);
  localparam logic [9:0] PULSE_LAST = 10'(PULSE_CYC - 1);
  localparam int         COIN1_IDX  = (NUM_COIN > 1) ? 1 : 0;

  logic                ion_r;
  logic [15:0]         wr_strb_r;
  logic [15:0]         rd_strb_r;
  logic [7:0]          db_out_r;
  logic [2:0]          pri_r;
  logic                bsl_r;
  logic                p1_p2n_r;
  logic [7:0]          rd_byte_s;
  logic                sub_s;
  logic [NUM_COIN-1:0] coin_dbn_s;
  logic [3:0]          unused_s;

  assign unused_s = DB_in[7:4];

  // Read mux; port 1 carries the debounced coin levels in its top bits.
  always_comb begin
    rd_byte_s = 8'hFF;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      rd_byte_s = (AB == 4'(k)) ? RD_PORTS[8*k +: 8] : rd_byte_s;
    end
    sub_s        = (NUM_RD_PORTS > 1) && (AB == 4'd1);
    rd_byte_s[7] = sub_s ? coin_dbn_s[0] : rd_byte_s[7];
    rd_byte_s[6] = (sub_s && (NUM_COIN > 1)) ? coin_dbn_s[COIN1_IDX] : rd_byte_s[6];
  end

  // Access edge detect, strobes, read data and control latches.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      ion_r     <= 1'b1;
      wr_strb_r <= 16'd0;
      rd_strb_r <= 16'd0;
      db_out_r  <= 8'hFF;
      pri_r     <= 3'd0;
      bsl_r     <= 1'b0;
      p1_p2n_r  <= 1'b0;
    end else begin
      ion_r <= IOn;
      if (ion_r && !IOn) begin
        wr_strb_r <= RW ? 16'd0 : (16'd1 << AB);
        rd_strb_r <= RW ? (16'd1 << AB) : 16'd0;
      end else begin
        wr_strb_r <= 16'd0;
        rd_strb_r <= 16'd0;
      end
      db_out_r <= (!IOn && RW) ? rd_byte_s : 8'hFF;
      if (wr_strb_r[13]) begin
        p1_p2n_r <= DB_in[0];
      end
      if (wr_strb_r[15]) begin
        {bsl_r, pri_r} <= DB_in[3:0];
      end
    end
  end

  assign DB_out   = db_out_r;
  assign WR_STRB  = wr_strb_r;
  assign RD_STRB  = rd_strb_r;
  assign PRI      = pri_r;
  assign BSL      = bsl_r;
  assign P1_P2n   = p1_p2n_r;
  assign COIN_DBn = coin_dbn_s;

  for (genvar i = 0; i < NUM_COIN; i++) begin : g_coin
    logic       sync1_r, sync2_r, last_r, dbn_r, cunt_r;
    logic [7:0] deb_cnt_r;
    logic [3:0] pend_r;
    logic [1:0] st_r;
    logic [9:0] tmr_r;
    logic       stable_s, fall_s, start_s;

    // deb_cnt_r holds the run length of sync2_r, so stable_s means DEB_CYC equal samples.
    always_comb begin
      stable_s = (sync2_r == last_r) && (deb_cnt_r >= DEB_LAST);
      fall_s   = stable_s && dbn_r && !sync2_r;
      if (pend_r == 4'd0) begin
        start_s = 1'b0;
      end else if (st_r == ST_IDLE) begin
        start_s = 1'b1;
      end else begin
        start_s = (st_r == ST_GAP) && (tmr_r == PULSE_LAST);
      end
    end

    // Two-flop synchroniser followed by the stability counter.
    always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
        sync1_r   <= 1'b1;
        sync2_r   <= 1'b1;
        last_r    <= 1'b1;
        deb_cnt_r <= 8'd0;
        dbn_r     <= 1'b1;
      end else begin
        sync1_r <= COINn[i];
        sync2_r <= sync1_r;
        last_r  <= sync2_r;
        if (sync2_r != last_r) begin
          deb_cnt_r <= 8'd1;
        end else if (deb_cnt_r != DEB_MAX) begin
          deb_cnt_r <= deb_cnt_r + 8'd1;
        end
        if (stable_s) begin
          dbn_r <= sync2_r;
        end
      end
    end

    // Pending-coin counter and pulse/gap sequencer; a queued coin follows a gap directly.
    always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
        pend_r <= 4'd0;
        st_r   <= ST_IDLE;
        tmr_r  <= 10'd0;
        cunt_r <= 1'b0;
      end else begin
        if (fall_s && !start_s) begin
          if (pend_r != 4'hF) begin
            pend_r <= pend_r + 4'd1;
          end
        end else if (start_s && !fall_s) begin
          pend_r <= pend_r - 4'd1;
        end
        case (st_r)
          ST_IDLE: begin
            tmr_r <= 10'd0;
            if (start_s) begin
              st_r   <= ST_PULSE;
              cunt_r <= 1'b1;
            end
          end
          ST_PULSE: begin
            if (tmr_r == PULSE_LAST) begin
              st_r   <= ST_GAP;
              tmr_r  <= 10'd0;
              cunt_r <= 1'b0;
            end else begin
              tmr_r <= tmr_r + 10'd1;
            end
          end
          ST_GAP: begin
            if (tmr_r == PULSE_LAST) begin
              tmr_r <= 10'd0;
              if (start_s) begin
                st_r   <= ST_PULSE;
                cunt_r <= 1'b1;
              end else begin
                st_r <= ST_IDLE;
              end
            end else begin
              tmr_r <= tmr_r + 10'd1;
            end
          end
          default: begin
            st_r   <= ST_IDLE;
            tmr_r  <= 10'd0;
            cunt_r <= 1'b0;
          end
        endcase
      end
    end

    assign coin_dbn_s[i] = dbn_r;
    assign CUNT[i]       = cunt_r;
  end

endmodule
